// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port round-robin arbiter in front of a shared data-memory/IO bus.
// Port 0 is the CPU, port 1 the IO/debug engine. Each granted access walks
// IDLE -> ISSUE -> CAPT -> DONE -> IDLE (4 cycles): the request is latched in
// IDLE, driven onto the shared bus for one cycle in ISSUE, read data is
// captured in CAPT, and the owner is acknowledged in DONE. Addresses are not
// decoded here; the memory/IO split happens downstream.

module dmem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0,
    input  logic             we0,
    input  logic [31:0]      addr0,
    input  logic [31:0]      wdata0,
    output logic             ack0,
    output logic [31:0]      rdata0,

    input  logic             req1,
    input  logic             we1,
    input  logic [31:0]      addr1,
    input  logic [31:0]      wdata1,
    output logic             ack1,
    output logic [31:0]      rdata1,

    output logic             m_en,
    output logic             m_we,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,

    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;

    // Access in flight: owning port and its latched request.
    logic             owner_q;
    logic             lat_we_q;
    logic [31:0]      lat_addr_q;
    logic [31:0]      lat_wdata_q;

    // Round-robin history. last_valid_q stays low until the first completed
    // access so that port 0 wins the first tie after reset.
    logic             last_valid_q;
    logic             last_served_q;

    logic             win_port;
    logic             start;

    logic [31:0]      rdata0_q;
    logic [31:0]      rdata1_q;
    logic [CNT_W-1:0] gcnt0_q;
    logic [CNT_W-1:0] gcnt1_q;

    // Pick the winner among the current requesters (round-robin on a tie)
    always_comb begin
        // NOTE: assign a default before any branch so every path drives the signal and no latch is inferred.
        win_port = 1'b0;
        if (req0 && req1) begin
            win_port = last_valid_q ? ~last_served_q : 1'b0;
        end else if (req1) begin
            win_port = 1'b1;
        end
    end

    assign start = (state_q == IDLE) && (req0 || req1);

    // State register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed four-cycle walk once a request is accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 || req1) state_d = ISSUE;
            ISSUE:   state_d = CAPT;
            CAPT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes and acknowledges decoded from the current state
    always_comb begin
        m_en = 1'b0;
        m_we = 1'b0;
        ack0 = 1'b0;
        ack1 = 1'b0;
        case (state_q)
            ISSUE: begin
                m_en = 1'b1;
                m_we = lat_we_q;
            end
            DONE: begin
                ack0 = ~owner_q;
                ack1 = owner_q;
            end
            default: begin
            end
        endcase
    end

    // Latch the winning port's request when the access is accepted; later
    // input changes cannot disturb the access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q     <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else if (start) begin
            owner_q     <= win_port;
            lat_we_q    <= win_port ? we1    : we0;
            lat_addr_q  <= win_port ? addr1  : addr0;
            lat_wdata_q <= win_port ? wdata1 : wdata0;
        end
    end

    // Remember who was served last, updated as the access completes
    always_ff @(posedge clock) begin
        if (reset) begin
            last_valid_q  <= 1'b0;
            last_served_q <= 1'b0;
        end else if (state_q == DONE) begin
            last_valid_q  <= 1'b1;
            last_served_q <= owner_q;
        end
    end

    // Capture read data into the owner's register only; writes leave it alone
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if ((state_q == CAPT) && !lat_we_q) begin
            if (owner_q) begin
                rdata1_q <= m_rdata;
            end else begin
                rdata0_q <= m_rdata;
            end
        end
    end

    // Saturating per-port grant counters, bumped on completion
    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (state_q == DONE) begin
            if (!owner_q && (gcnt0_q != CNT_MAX)) begin
                gcnt0_q <= gcnt0_q + CNT_ONE;
            end
            if (owner_q && (gcnt1_q != CNT_MAX)) begin
                gcnt1_q <= gcnt1_q + CNT_ONE;
            end
        end
    end

    // The full latched address and data are forwarded unchanged
    assign m_addr  = lat_addr_q;
    assign m_wdata = lat_wdata_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign gcnt0   = gcnt0_q;
    assign gcnt1   = gcnt1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the per-port grant counters.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1, access request from port 0 (CPU) and port 1 (IO/debug engine).
REQ-005 The block SHALL have ports we0 and we1, input, 1, write (1) or read (0) qualifier for each port.
REQ-006 The block SHALL have ports addr0 and addr1, input, 32, byte address for each port.
REQ-007 The block SHALL have ports wdata0 and wdata1, input, 32, write data for each port.
REQ-008 The block SHALL have ports ack0 and ack1, output, 1, one-cycle completion pulse per port.
REQ-009 The block SHALL have ports rdata0 and rdata1, output, 32, registered read data per port.
REQ-010 The block SHALL have ports m_en and m_we, output, 1 each, shared memory/IO access strobe and write enable.
REQ-011 The block SHALL have ports m_addr and m_wdata, output, 32 each, shared address and write data.
REQ-012 The block SHALL have port m_rdata, input, 32, shared read data, valid one cycle after m_en.
REQ-013 The block SHALL have ports gcnt0 and gcnt1, output, CNT_W each, count of completed grants per port.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, CAPT and DONE; each access SHALL take exactly one pass IDLE->ISSUE->CAPT->DONE->IDLE, i.e. 4 cycles.
REQ-015 In IDLE with req0 or req1 high, the FSM SHALL select the winner, latch that port's we, addr and wdata into internal registers, record the owner, and move to ISSUE; with no request it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a single requester always wins; on simultaneous requests the port not served last wins.
REQ-017 The last-served pointer SHALL update in DONE to the owner.
REQ-018 In ISSUE, m_en SHALL be 1, m_we SHALL equal the latched we, and m_addr and m_wdata SHALL equal the latched values; the FSM SHALL then move to CAPT.
REQ-019 In all other states, m_en and m_we SHALL be 0.
REQ-020 In CAPT, for a read, m_rdata SHALL be registered into the owner's rdata register; for a write, rdata SHALL be unchanged; the FSM SHALL then move to DONE.
REQ-021 The non-owner's rdata SHALL never change.
REQ-022 In DONE, ack of the owner only SHALL be 1 for exactly one cycle, the owner's gcnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-023 gcnt SHALL saturate at all-ones.
REQ-024 Requester rule: req, we, addr and wdata SHALL be held stable from req assertion until ack; req still high in the cycle after ack SHALL be treated as a new request.
REQ-025 Changes to req, addr or wdata during ISSUE, CAPT or DONE SHALL NOT affect the access in flight.
REQ-026 Fairness: a waiting requester SHALL be granted after at most one access by the other port, i.e. within 8 cycles of req.
REQ-027 The block SHALL NOT decode addresses; the memory/IO split is done downstream.
REQ-028 The full 32-bit address SHALL be forwarded unchanged.

Reset
REQ-029 While reset is high at a clock edge, the state SHALL become IDLE.
REQ-030 Reset SHALL clear the last-served pointer so that port 0 wins the first tie.
REQ-031 Reset SHALL force ack0, ack1, m_en and m_we to 0.
REQ-032 Reset SHALL clear m_addr, m_wdata, rdata0, rdata1, gcnt0 and gcnt1 to 0.
REQ-033 A reset during ISSUE, CAPT or DONE SHALL abort the access: no ack SHALL be issued afterwards and no counter SHALL increment.
REQ-034 An in-progress request SHALL be re-arbitrated after reset only if req is still high.

Verification
REQ-035 Read: after reset, req0=1, we0=0, addr0=0x10, m_rdata=0x1234 in CAPT -> m_en high in cycle 2 with m_addr=0x10; ack0 in cycle 4; rdata0=0x1234; gcnt0=1; ack1 stays 0.
REQ-036 Tie: req0 and req1 asserted together after reset -> port 0 served first (ack0 at cycle 4), port 1 next (ack1 at cycle 8); a second simultaneous pair -> port 0 first again.
REQ-037 Streaming: req0 held continuously with req1 asserted -> grants alternate 0,1,0,1; neither port waits more than 8 cycles.
REQ-038 Write: req1=1, we1=1, addr1=0x80, wdata1=0x2A -> m_we high for exactly one cycle with m_addr=0x80 and m_wdata=0x2A; rdata1 unchanged; ack1 pulses once.
REQ-039 Abort: reset asserted in CAPT -> no ack; next cycle m_en=0; all outputs 0; gcnt unchanged at 0.
REQ-040 Saturation: gcnt0 preloaded by 2^CNT_W port-0 accesses -> gcnt0 remains 0xFFFF on further grants.
